// File: rtl/eq_gain_pkg.sv
// Shared definitions for the equaliser gain stage: rounding encodings, FSM states
// and constant helpers for unity gain and saturation limits.
package eq_gain_pkg;

    localparam int ROUND_FLOOR   = 0;
    localparam int ROUND_HALF_UP = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bgs_state_t;

    function automatic int unity_gain(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

    // Half-LSB of the post-shift result; zero when there are no fractional bits.
    function automatic int round_bias(input int frac_bits);
        return (frac_bits > 0) ? (1 << (frac_bits - 1)) : 0;
    endfunction

endpackage

// File: rtl/gain_round_sat.sv
// Combinational sample x gain multiply, optional round-half-up, fractional shift
// and saturation to the sample width with an overflow flag.
module gain_round_sat
    import eq_gain_pkg::*;
#(
    parameter int FILTER_IN_BITS = 16,
    parameter int GAIN_BITS      = 8,
    parameter int GAIN_FRAC_BITS = 4,
    parameter int ROUND_MODE     = 1
) (
    input  logic signed [FILTER_IN_BITS-1:0] sample,
    input  logic signed [GAIN_BITS-1:0]      gain,
    output logic signed [FILTER_IN_BITS-1:0] result,
    output logic                             sat
);

    localparam int W  = FILTER_IN_BITS;
    localparam int PW = FILTER_IN_BITS + GAIN_BITS + 1;
    localparam int RW = PW - GAIN_FRAC_BITS;

    localparam logic signed [PW-1:0] RND  = (ROUND_MODE == ROUND_HALF_UP) ? PW'(round_bias(GAIN_FRAC_BITS)) : '0;
    localparam logic signed [RW-1:0] SMAX = RW'(sat_max(W));
    localparam logic signed [RW-1:0] SMIN = RW'(sat_min(W));

    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] biased;
    logic signed [RW-1:0] shifted;

    always_comb begin
        s_ext   = {{(PW-W){sample[W-1]}}, sample};
        g_ext   = {{(PW-GAIN_BITS){gain[GAIN_BITS-1]}}, gain};
        biased  = (s_ext * g_ext) + RND;
        shifted = RW'(biased >>> GAIN_FRAC_BITS);
        sat     = 1'b0;
        result  = shifted[W-1:0];
        if (shifted > SMAX) begin
            result = {1'b0, {(W-1){1'b1}}};
            sat    = 1'b1;
        end else if (shifted < SMIN) begin
            result = {1'b1, {(W-1){1'b0}}};
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/band_gain_sequencer.sv
// Time-multiplexed per-band gain stage: one multiplier walks all bands per sample,
// ramping each band's current gain toward its written target.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// RUN   | one band per cycle issued to the multiplier, gain ramp applied
// DRAIN | pipeline empties, then bus/flags publish with out_valid
module band_gain_sequencer
    import eq_gain_pkg::*;
#(
    parameter int NUMBER_OF_FILTERS = 10,
    parameter int GAIN_BITS         = 8,
    parameter int GAIN_FRAC_BITS    = 4,
    parameter int FILTER_IN_BITS    = 16,
    parameter int RAMP_STEP         = 1,
    parameter int ROUND_MODE        = 1,
    localparam int IDX_BITS         = $clog2(NUMBER_OF_FILTERS)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic signed [FILTER_IN_BITS-1:0]            filter_in,
    input  logic                                        gain_wr_en,
    input  logic [IDX_BITS-1:0]                         gain_wr_idx,
    input  logic signed [GAIN_BITS-1:0]                 gain_wr_data,
    output logic                                        out_valid,
    output logic [NUMBER_OF_FILTERS*FILTER_IN_BITS-1:0] amplified_filter_ins,
    output logic [NUMBER_OF_FILTERS-1:0]                sat_flags
);

    localparam int N = NUMBER_OF_FILTERS;
    localparam int W = FILTER_IN_BITS;
    localparam int G = GAIN_BITS;
    localparam logic signed [G-1:0] UNITY = G'(unity_gain(GAIN_FRAC_BITS));

    bgs_state_t           state;
    logic [IDX_BITS-1:0]  cnt;
    logic [IDX_BITS-1:0]  p_idx;
    logic signed [W-1:0]  sample_q;
    logic                 en_q;
    logic                 p_val;
    logic signed [W-1:0]  p_res;
    logic                 p_sat;
    logic signed [G-1:0]  gain_cur [N];
    logic signed [G-1:0]  gain_tgt [N];
    logic signed [W-1:0]  stg_res  [N];
    logic [N-1:0]         stg_sat;

    logic signed [G-1:0]  cur_sel;
    logic signed [G-1:0]  tgt_sel;
    logic signed [G-1:0]  slot_gain;
    logic signed [G-1:0]  ramp_next;
    logic signed [W-1:0]  rs_result;
    logic                 rs_sat;
    int                   diff;

    // With no ramp the slot sees the target directly, so a jump takes effect on the very next sample.
    always_comb begin
        cur_sel   = gain_cur[cnt];
        tgt_sel   = gain_tgt[cnt];
        slot_gain = (RAMP_STEP == 0) ? tgt_sel : cur_sel;
        diff      = int'(tgt_sel) - int'(cur_sel);
        if (RAMP_STEP == 0 || (diff <= RAMP_STEP && diff >= -RAMP_STEP)) begin
            ramp_next = tgt_sel;
        end else if (diff > 0) begin
            ramp_next = cur_sel + G'(RAMP_STEP);
        end else begin
            ramp_next = cur_sel - G'(RAMP_STEP);
        end
    end

    gain_round_sat #(
        .FILTER_IN_BITS (W),
        .GAIN_BITS      (G),
        .GAIN_FRAC_BITS (GAIN_FRAC_BITS),
        .ROUND_MODE     (ROUND_MODE)
    ) u_round_sat (
        .sample (sample_q),
        .gain   (slot_gain),
        .result (rs_result),
        .sat    (rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) gain_tgt[i] <= UNITY;
        end else if (gain_wr_en && int'(gain_wr_idx) < N) begin
            gain_tgt[gain_wr_idx] <= gain_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            sample_q             <= '0;
            en_q                 <= 1'b0;
            p_val                <= 1'b0;
            p_idx                <= '0;
            p_res                <= '0;
            p_sat                <= 1'b0;
            stg_sat              <= '0;
            in_ready             <= 1'b1;
            out_valid            <= 1'b0;
            amplified_filter_ins <= '0;
            sat_flags            <= '0;
            for (int i = 0; i < N; i++) begin
                gain_cur[i] <= UNITY;
                stg_res[i]  <= '0;
            end
        end else begin
            p_val     <= 1'b0;
            out_valid <= 1'b0;
            if (p_val) begin
                stg_res[p_idx] <= p_res;
                stg_sat[p_idx] <= p_sat;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sample_q <= filter_in;
                        en_q     <= en;
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    p_val         <= 1'b1;
                    p_idx         <= cnt;
                    p_res         <= en_q ? rs_result : sample_q;
                    p_sat         <= en_q & rs_sat;
                    gain_cur[cnt] <= ramp_next;
                    if (cnt == IDX_BITS'(N - 1)) begin
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + IDX_BITS'(1);
                    end
                end
                DRAIN: begin
                    // Wait one cycle for the last band to leave the product register.
                    if (!p_val) begin
                        for (int k = 0; k < N; k++) amplified_filter_ins[k*W +: W] <= stg_res[k];
                        sat_flags <= stg_sat;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_band_gain_sequencer.sv
// Scoreboard bench: three instances (ramped/round, jump/round, jump/floor) share one
// stimulus stream; expected bus/flags/latency are queued at accept and popped on out_valid.
module tb_band_gain_sequencer;

    localparam int N = 10;
    localparam int W = 16;
    localparam int D = 3;

    typedef struct {
        logic [N*W-1:0] bus;
        logic [N-1:0]   flags;
        int             acc;
        int             tag;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic signed [W-1:0] filter_in;
    logic               gain_wr_en;
    logic [3:0]         gain_wr_idx;
    logic signed [7:0]  gain_wr_data;
    logic [D-1:0]       wr_mask;
    logic [D-1:0]       wr_en_v;
    logic [D-1:0]       in_ready_v;
    logic [D-1:0]       out_valid_v;
    logic [N*W-1:0]     bus_v   [D];
    logic [N-1:0]       flags_v [D];

    exp_t               exp_q [D][$];
    exp_t               mon_e;
    logic [N*W-1:0]     stage_bus   [D];
    logic [N-1:0]       stage_flags [D];
    int                 cyc = 0;
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 last_acc = 0;
    int                 prev_acc = 0;
    logic               ov_at_acc;

    assign wr_en_v = {D{gain_wr_en}} & wr_mask;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    band_gain_sequencer u_dut0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .filter_in(filter_in), .gain_wr_en(wr_en_v[0]), .gain_wr_idx(gain_wr_idx),
        .gain_wr_data(gain_wr_data), .out_valid(out_valid_v[0]),
        .amplified_filter_ins(bus_v[0]), .sat_flags(flags_v[0])
    );

    band_gain_sequencer #(.RAMP_STEP(0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .filter_in(filter_in), .gain_wr_en(wr_en_v[1]), .gain_wr_idx(gain_wr_idx),
        .gain_wr_data(gain_wr_data), .out_valid(out_valid_v[1]),
        .amplified_filter_ins(bus_v[1]), .sat_flags(flags_v[1])
    );

    band_gain_sequencer #(.RAMP_STEP(0), .ROUND_MODE(0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .filter_in(filter_in), .gain_wr_en(wr_en_v[2]), .gain_wr_idx(gain_wr_idx),
        .gain_wr_data(gain_wr_data), .out_valid(out_valid_v[2]),
        .amplified_filter_ins(bus_v[2]), .sat_flags(flags_v[2])
    );

    task automatic chk(input string nm, input int d, input int tag,
                       input logic [191:0] got, input logic [191:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d tag%0d: got %0h want %0h", nm, d, tag, got, want);
        end
    endtask

    function automatic logic [N*W-1:0] bus_of(input int all, input int band, input int v);
        logic [N*W-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = (k == band) ? 16'(v) : 16'(all);
        return b;
    endfunction

    task automatic set_exp(input int d, input int all, input int band, input int v, input bit sat);
        stage_bus[d]   = bus_of(all, band, v);
        stage_flags[d] = sat ? (N'(1) << band) : '0;
    endtask

    task automatic set_all(input int v);
        for (int d = 0; d < D; d++) set_exp(d, v, -1, 0, 1'b0);
    endtask

    task automatic send(input int s, input bit e_in, input int tag);
        int n = 0;
        @(negedge clk);
        filter_in = 16'(s);
        en        = e_in;
        in_valid  = 1'b1;
        while (!in_ready_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 0, tag, 192'(n < 50), 192'(1));
        if (n >= 50) begin
            in_valid = 1'b0;
            return;
        end
        ov_at_acc = out_valid_v[0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        prev_acc = last_acc;
        last_acc = cyc;
        for (int d = 0; d < D; d++)
            exp_q[d].push_back('{bus: stage_bus[d], flags: stage_flags[d], acc: cyc, tag: tag});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 0, 0, 192'(n < 50), 192'(1));
    endtask

    task automatic write_gain(input logic [D-1:0] mask, input int idx, input int data);
        @(negedge clk);
        wait_idle();
        wr_mask      = mask;
        gain_wr_idx  = 4'(idx);
        gain_wr_data = 8'(data);
        gain_wr_en   = 1'b1;
        @(negedge clk);
        gain_wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_wait", 0, 0, 192'(n < 200), 192'(1));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < D; i++) begin
            if (out_valid_v[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid dut%0d: got out_valid 1 want 0", i);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    chk("bus", i, mon_e.tag, 192'(bus_v[i]), 192'(mon_e.bus));
                    chk("flags", i, mon_e.tag, 192'(flags_v[i]), 192'(mon_e.flags));
                    chk("latency", i, mon_e.tag, 192'(cyc - mon_e.acc), 192'(12));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ramp [6] = '{1000, 1063, 1125, 1188, 1250, 1250};
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; filter_in = '0;
        gain_wr_en = 1'b0; gain_wr_idx = '0; gain_wr_data = '0; wr_mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < D; d++)
            chk("reset_state", d, 0, 192'({in_ready_v[d], out_valid_v[d], flags_v[d], bus_v[d]}),
                192'({1'b1, 1'b0, 10'b0, 160'b0}));

        set_all(1000);
        send(1000, 1'b1, 1);

        write_gain(3'b110, 0, 127);
        set_exp(0, 30000, -1, 0, 1'b0);
        set_exp(1, 30000, 0, 32767, 1'b1);
        set_exp(2, 30000, 0, 32767, 1'b1);
        send(30000, 1'b1, 2);
        set_exp(0, -30000, -1, 0, 1'b0);
        set_exp(1, -30000, 0, -32768, 1'b1);
        set_exp(2, -30000, 0, -32768, 1'b1);
        send(-30000, 1'b1, 3);

        write_gain(3'b110, 0, 24);
        set_exp(0, 3, -1, 0, 1'b0);
        set_exp(1, 3, 0, 5, 1'b0);
        set_exp(2, 3, 0, 4, 1'b0);
        send(3, 1'b1, 4);
        set_exp(0, -3, -1, 0, 1'b0);
        set_exp(1, -3, 0, -4, 1'b0);
        set_exp(2, -3, 0, -5, 1'b0);
        send(-3, 1'b1, 5);

        write_gain(3'b001, 2, 20);
        for (int j = 0; j < 6; j++) begin
            set_exp(0, 1000, 2, ramp[j], 1'b0);
            set_exp(1, 1000, 0, 1500, 1'b0);
            set_exp(2, 1000, 0, 1500, 1'b0);
            send(1000, 1'b1, 6 + j);
        end

        set_all(-1234);
        send(-1234, 1'b0, 12);
        write_gain(3'b111, 12, 100);
        set_exp(0, 1000, 2, 1250, 1'b0);
        set_exp(1, 1000, 0, 1500, 1'b0);
        set_exp(2, 1000, 0, 1500, 1'b0);
        send(1000, 1'b1, 13);

        drain();
        @(negedge clk);
        filter_in = 16'sd1000; en = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < D; d++)
            chk("post_reset", d, 0, 192'({in_ready_v[d], out_valid_v[d], flags_v[d], bus_v[d]}),
                192'({1'b1, 1'b0, 10'b0, 160'b0}));
        repeat (20) @(negedge clk);

        set_all(500);
        send(500, 1'b1, 14);
        set_all(700);
        send(700, 1'b1, 15);
        chk("b2b_out_valid_at_accept", 0, 15, 192'(ov_at_acc), 192'(1));
        chk("b2b_accept_gap", 0, 15, 192'(last_acc - prev_acc), 192'(13));

        drain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
